libhdl_ocmem_sp_ctrl: RTL and testbench

//   Initiator for one single-port on-chip memory port (1-cycle registered read, any write mode).

---
 rtl/libhdl_ocmem_sp_ctrl.sv | 109 ++++++++++
 tb/tb_libhdl_ocmem_sp_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/libhdl_ocmem_sp_ctrl.sv
// Command/response initiator for one single-port on-chip memory with a 1-cycle registered read.
// Define LIBHDL_OCMEM_CTRL_WACK_EN to return a write ack per write; LIBHDL_ASSERT enables overflow checking.
module libhdl_ocmem_sp_ctrl #(
    parameter int W         = 32,
    parameter int D         = 1024,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [$clog2(D)-1:0] i_cmd_addr,
    input  logic [W-1:0]         i_cmd_wdat,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [W-1:0]         o_rsp_rdat,
    output logic                 o_rsp_wr,
    output logic                 o_mem_we,
    output logic [$clog2(D)-1:0] o_mem_addr,
    output logic [W-1:0]         o_mem_wdat,
    input  logic [W-1:0]         i_mem_rdat
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_pend_p1;
    logic          fire;
    logic          push_rd;
    logic          push_ack;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [CW-1:0] n_push;
    logic [W-1:0]  fifo_dat [RSP_DEPTH];

    // Credit counts the in-flight read so the FIFO can always absorb it.
    assign credit_used = {1'b0, cnt} + {{CW{1'b0}}, rd_pend_p1};
    assign o_cmd_ready = i_rst_n & (credit_used < (CW+1)'(RSP_DEPTH));
    assign fire        = i_cmd_valid & o_cmd_ready;

    assign o_mem_we    = fire & i_cmd_we;
    assign o_mem_addr  = i_cmd_addr;
    assign o_mem_wdat  = i_cmd_wdat;

    assign push_rd     = rd_pend_p1;
    assign pop         = o_rsp_valid & i_rsp_ready;
    assign o_rsp_valid = (cnt != '0);
    assign o_rsp_rdat  = fifo_dat[rd_ptr];

`ifdef LIBHDL_OCMEM_CTRL_WACK_EN
    logic          fifo_wr [RSP_DEPTH];
    logic [PW-1:0] ack_ptr;

    // An ack landing with a read capture takes the slot behind the read, which fired first.
    assign push_ack = fire & i_cmd_we;
    assign ack_ptr  = wr_ptr + PW'(rd_pend_p1);
    assign o_rsp_wr = fifo_wr[rd_ptr];
`else
    assign push_ack = 1'b0;
    assign o_rsp_wr = 1'b0;
`endif

    assign n_push = CW'(push_rd) + CW'(push_ack);

    // p0: command fires, memory samples address; p1: read data captured from the memory
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pend_p1 <= 1'b0;
        end else begin
            rd_pend_p1 <= fire & ~i_cmd_we;
            wr_ptr     <= wr_ptr + n_push[PW-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + n_push - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_rd) begin
            fifo_dat[wr_ptr] <= i_mem_rdat;
        end
`ifdef LIBHDL_OCMEM_CTRL_WACK_EN
        if (push_rd) begin
            fifo_wr[wr_ptr] <= 1'b0;
        end
        if (push_ack) begin
            fifo_dat[ack_ptr] <= '0;
            fifo_wr[ack_ptr]  <= 1'b1;
        end
`endif
    end

`ifdef LIBHDL_ASSERT
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (({1'b0, cnt} + {1'b0, n_push}) <= (CW+1)'(RSP_DEPTH))
            else $error("libhdl_ocmem_sp_ctrl: response FIFO overflow");
        end
    end
`endif

endmodule

// File: tb/tb_libhdl_ocmem_sp_ctrl.sv
// Directed bench for libhdl_ocmem_sp_ctrl with a behavioural single-port memory and response scoreboard.
// Honours LIBHDL_OCMEM_CTRL_WACK_EN so the same stimulus covers the write-ack build.
module tb_libhdl_ocmem_sp_ctrl;
    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdat;
    logic          rsp_valid, rsp_ready, rsp_wr;
    logic [W-1:0]  rsp_rdat;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdat;
    logic [W-1:0]  mem_rdat;

    always #5 clk = ~clk;

    libhdl_ocmem_sp_ctrl #(.W(W), .D(D), .RSP_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_addr(cmd_addr), .i_cmd_wdat(cmd_wdat),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdat(rsp_rdat), .o_rsp_wr(rsp_wr),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdat(mem_wdat),
        .i_mem_rdat(mem_rdat)
    );

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        return 32'h1234_0000 | {22'b0, a};
    endfunction

    // Memory model: unwritten words read back as pat(addr), registered read.
    bit          mem_wv  [D];
    logic [31:0] mem_val [D];
    always @(posedge clk) begin
        if (mem_we) begin
            mem_wv[mem_addr]  <= 1'b1;
            mem_val[mem_addr] <= mem_wdat;
        end
        mem_rdat <= mem_wv[mem_addr] ? mem_val[mem_addr] : pat(mem_addr);
    end

    logic [31:0] ref_mem [D];
    logic [32:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic rdy, output logic fired);
        logic [32:0] e;
        @(posedge clk); #1;
        cmd_valid = v; cmd_we = we; cmd_addr = a; cmd_wdat = wd; rsp_ready = rdy;
        @(negedge clk);
        fired = v & cmd_ready;
        if (rsp_valid && rdy) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_extra: got %0h expected no response", rsp_rdat);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdat", {32'b0, rsp_rdat}, {32'b0, e[31:0]});
                chk("rsp_wr", {63'b0, rsp_wr}, {63'b0, e[32]});
            end
        end
        if (fired) begin
            if (we) begin
                ref_mem[a] = wd;
`ifdef LIBHDL_OCMEM_CTRL_WACK_EN
                exp_q.push_back({1'b1, 32'h0});
`endif
            end else begin
                exp_q.push_back({1'b0, ref_mem[a]});
            end
        end
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic rdy, output logic mwe);
        logic f;
        int   n;
        f = 1'b0;
        n = 0;
        mwe = 1'b0;
        while (!f && n < 20) begin
            cyc(1'b1, we, a, wd, rdy, f);
            mwe = mem_we;
            n++;
        end
        if (!f) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: got no fire expected fire at addr %0h", a);
        end
    endtask

    task automatic drain();
        logic f;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1, f);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, f);
        chk("drain_idle", {63'b0, rsp_valid}, 64'd0);
    endtask

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic          rdy;
        logic          e_crdy;
        logic          e_rvld;
        logic [31:0]   e_rdat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic f, mwe;
        int   k;
        int   pop0;

        for (int i = 0; i < D; i++) ref_mem[i] = pat(AW'(i));
        tbl[0]  = '{1'b1, 1'b0, 10'h010, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 10'h001, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b0, 10'h002, 1'b1, 1'b1, 1'b1, 32'h12340000};
        tbl[4]  = '{1'b1, 1'b0, 10'h003, 1'b1, 1'b1, 1'b1, 32'h12340001};
        tbl[5]  = '{1'b1, 1'b0, 10'h004, 1'b1, 1'b1, 1'b1, 32'h12340002};
        tbl[6]  = '{1'b1, 1'b0, 10'h005, 1'b1, 1'b1, 1'b1, 32'h12340003};
        tbl[7]  = '{1'b1, 1'b0, 10'h006, 1'b1, 1'b1, 1'b1, 32'h12340004};
        tbl[8]  = '{1'b1, 1'b0, 10'h007, 1'b1, 1'b1, 1'b1, 32'h12340005};
        tbl[9]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 32'h12340006};
        tbl[10] = '{1'b0, 1'b0, 10'h001, 1'b1, 1'b1, 1'b1, 32'h12340007};
        tbl[11] = '{1'b0, 1'b0, 10'h002, 1'b1, 1'b1, 1'b0, 32'h0};

        // Reset held with a write command presented
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h010;
        cmd_wdat = 32'h0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
        chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_rsp_wr", {63'b0, rsp_wr}, 64'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'b0, cmd_ready}, 64'd1);
        chk("post_rst_valid", {63'b0, rsp_valid}, 64'd0);

        // Write DEADBEEF @0x010, then the cycle table reads it back followed by reads 0..7
        issue(1'b1, 10'h010, 32'hDEADBEEF, 1'b1, mwe);
        chk("wr_mem_we", {63'b0, mwe}, 64'd1);
        drain();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            cmd_valid = tbl[i].v; cmd_we = tbl[i].we; cmd_addr = tbl[i].a;
            cmd_wdat = 32'h0; rsp_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_cmd_ready", i), {63'b0, cmd_ready}, {63'b0, tbl[i].e_crdy});
            chk($sformatf("tbl%0d_mem_we", i), {63'b0, mem_we}, 64'd0);
            chk($sformatf("tbl%0d_rsp_valid", i), {63'b0, rsp_valid}, {63'b0, tbl[i].e_rvld});
            if (tbl[i].e_rvld)
                chk($sformatf("tbl%0d_rsp_rdat", i), {32'b0, rsp_rdat}, {32'b0, tbl[i].e_rdat});
        end

        // Six reads against a stalled response port
        k = 0;
        pop0 = n_pop;
        for (int n = 0; n < 8; n++) begin
            cyc(1'b1, 1'b0, 10'(32'h20 + k), 32'h0, 1'b0, f);
            if (f) k++;
        end
        chk("stall_fires", 64'(k), 64'd4);
        chk("stall_ready", {63'b0, cmd_ready}, 64'd0);
        chk("stall_valid", {63'b0, rsp_valid}, 64'd1);
        chk("stall_hold", {32'b0, rsp_rdat}, 64'h12340020);
        issue(1'b0, 10'h024, 32'h0, 1'b1, mwe);
        issue(1'b0, 10'h025, 32'h0, 1'b1, mwe);
        drain();
        chk("stall_pops", 64'(n_pop - pop0), 64'd6);

        // Read at the top address while the memory output keeps changing
        cyc(1'b1, 1'b0, 10'h3FF, 32'h0, 1'b0, f);
        chk("wrap_fire", {63'b0, f}, 64'd1);
        for (int j = 0; j < 4; j++) cyc(1'b0, 1'b0, AW'(j), 32'h0, 1'b0, f);
        chk("wrap_valid", {63'b0, rsp_valid}, 64'd1);
        chk("wrap_hold", {32'b0, rsp_rdat}, 64'h123403FF);
        drain();

        // Reset between a write and a read: responses dropped, write kept
        issue(1'b1, 10'h005, 32'h0BADCAFE, 1'b0, mwe);
        issue(1'b0, 10'h005, 32'h0, 1'b0, mwe);
        @(posedge clk); #1;
        cmd_valid = 1'b0; rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_mid_ready", {63'b0, cmd_ready}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, '0, '0, 1'b1, f);
        chk("rst_mid_empty", {63'b0, rsp_valid}, 64'd0);
        issue(1'b0, 10'h005, 32'h0, 1'b1, mwe);
        drain();

        // Interleaved writes and read-after-write with a toggling response port
        for (int i = 0; i < 8; i++) begin
            issue(~1'(i % 2), 10'(32'h40 + i / 2), 32'hA000_0000 + 32'(i), 1'((i >> 1) & 1), mwe);
        end
        drain();

        // Write then read of the same word, back to back
        issue(1'b1, 10'h005, 32'h5555AAAA, 1'b1, mwe);
        issue(1'b0, 10'h005, 32'h0, 1'b1, mwe);
        issue(1'b1, 10'h006, 32'h6666BBBB, 1'b1, mwe);
        issue(1'b0, 10'h006, 32'h0, 1'b1, mwe);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
